// File: rtl/lv_arbiter_if.sv
// LV write port: one offer (valid/idx/lv) toward the shared LV bank, ack back.
// master = lv_arbiter side, slave = LV storage side.
interface lv_arbiter_if #(
  parameter int p_width = 20,
  parameter int p_idx_w = 3
);
  logic               o_valid;
  logic [p_idx_w-1:0] o_idx;
  logic [p_width-1:0] o_lv;
  logic               i_ack;

  modport master (
    output o_valid,
    output o_idx,
    output o_lv,
    input  i_ack
  );

  modport slave (
    input  o_valid,
    input  o_idx,
    input  o_lv,
    output i_ack
  );
endinterface

// File: rtl/lv_arbiter.sv
// lv_arbiter: captures synapse values on spike rising edges and serialises
// them onto one LV write port (lv: o_valid/o_idx/o_lv out, i_ack in).
// Ports: i_clk, i_rst_n (sync, active-low), i_spike, i_sv (packed values),
// lv (master modport), o_pending (per-neuron), o_overflow (sticky).
// Build option: LV_ARB_FIXED_PRIO_EN selects lowest-index-first priority;
// default is round-robin.
module lv_arbiter #(
  parameter int p_neurons = 8,
  parameter int p_width   = 20,
  parameter int p_idx_w   = 3
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [p_neurons-1:0]         i_spike,
  input  logic [p_neurons*p_width-1:0] i_sv,
  lv_arbiter_if.master                 lv,
  output logic [p_neurons-1:0]         o_pending,
  output logic                         o_overflow
);

  typedef enum logic {
    S_IDLE,
    S_OFFER
  } state_t;

  state_t               state, state_n;
  logic [p_neurons-1:0] spike_d;
  logic [p_neurons-1:0] pending, pending_n;
  logic [p_width-1:0]   cap   [p_neurons];
  logic [p_width-1:0]   cap_n [p_neurons];
  logic [p_idx_w-1:0]   ptr, ptr_n;
  logic                 overflow, overflow_n;
  logic                 valid, valid_n;
  logic [p_idx_w-1:0]   idx, idx_n;
  logic [p_width-1:0]   lv_q, lv_n;

  logic [p_neurons-1:0] rise;
  logic [p_neurons-1:0] clr;
  logic                 found;
  logic [p_idx_w-1:0]   win;

  assign rise = i_spike & ~spike_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      spike_d  <= '0;
      pending  <= '0;
      ptr      <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
      idx      <= '0;
      lv_q     <= '0;
      for (int n = 0; n < p_neurons; n++) begin
        cap[n] <= '0;
      end
    end else begin
      state    <= state_n;
      spike_d  <= i_spike;
      pending  <= pending_n;
      ptr      <= ptr_n;
      overflow <= overflow_n;
      valid    <= valid_n;
      idx      <= idx_n;
      lv_q     <= lv_n;
      for (int n = 0; n < p_neurons; n++) begin
        cap[n] <= cap_n[n];
      end
    end
  end

  always_comb begin
    state_n    = state;
    valid_n    = valid;
    idx_n      = idx;
    lv_n       = lv_q;
    ptr_n      = ptr;
    clr        = '0;
    found      = 1'b0;
    win        = '0;
    for (int n = 0; n < p_neurons; n++) begin
      cap_n[n] = cap[n];
    end

    // Scan from ptr with wrap; ptr stays 0 in the fixed-priority build,
    // which turns this into a lowest-index-first search.
    for (int i = 0; i < p_neurons; i++) begin
      if (!found && pending[(int'(ptr) + i) % p_neurons]) begin
        found = 1'b1;
        win   = p_idx_w'((int'(ptr) + i) % p_neurons);
      end
    end

    if (state == S_OFFER && lv.i_ack) begin
      clr[idx] = 1'b1;
    end

    unique case (state)
      S_IDLE: begin
        if (found) begin
          state_n = S_OFFER;
          valid_n = 1'b1;
          idx_n   = win;
          lv_n    = cap[win];
        end
      end
      S_OFFER: begin
        if (lv.i_ack) begin
          state_n = S_IDLE;
          valid_n = 1'b0;
`ifdef LV_ARB_FIXED_PRIO_EN
          ptr_n   = '0;
`else
          if (int'(idx) == p_neurons - 1) begin
            ptr_n = '0;
          end else begin
            ptr_n = idx + 1'b1;
          end
`endif
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // A rise on the index being acked re-arms it without flagging overflow.
    for (int n = 0; n < p_neurons; n++) begin
      if (rise[n]) begin
        cap_n[n] = i_sv[n*p_width +: p_width];
      end
    end
    pending_n  = (pending & ~clr) | rise;
    overflow_n = overflow | (|(rise & pending & ~clr));
  end

  assign lv.o_valid = valid;
  assign lv.o_idx   = idx;
  assign lv.o_lv    = lv_q;
  assign o_pending  = pending;
  assign o_overflow = overflow;

endmodule

// File: tb/tb_lv_arbiter.sv
// Directed bench for lv_arbiter: reset, single spike, arbitration order,
// backpressure, overflow, ack/spike race and mid-offer reset.
module tb_lv_arbiter;

  localparam int N = 8;
  localparam int W = 20;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   spike;
  logic [N*W-1:0] sv;
  logic [N-1:0]   pending;
  logic           ovf;

  int vectors;
  int miscompares;

  lv_arbiter_if #(.p_width(W), .p_idx_w(3)) lv ();

  lv_arbiter #(
    .p_neurons(N),
    .p_width  (W),
    .p_idx_w  (3)
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_spike   (spike),
    .i_sv      (sv),
    .lv        (lv),
    .o_pending (pending),
    .o_overflow(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_sv(input int n, input logic [W-1:0] v);
    sv[n*W +: W] = v;
  endtask

  task automatic offer(input string tag, input logic [2:0] i,
                       input logic [W-1:0] v);
    chk({tag, "_valid"}, 32'(lv.o_valid), 32'd1);
    chk({tag, "_idx"}, 32'(lv.o_idx), 32'(i));
    chk({tag, "_lv"}, 32'(lv.o_lv), 32'(v));
    tick;
    chk({tag, "_drop"}, 32'(lv.o_valid), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(lv.o_valid), 32'd0);
    chk({tag, "_idx"}, 32'(lv.o_idx), 32'd0);
    chk({tag, "_lv"}, 32'(lv.o_lv), 32'd0);
    chk({tag, "_pend"}, 32'(pending), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    spike = '0;
    lv.i_ack = 1'b0;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n    = 1'b0;
    spike    = '0;
    sv       = '0;
    lv.i_ack = 1'b0;
    tick;
    tick;
    chk_reset("rst");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("idle_valid", 32'(lv.o_valid), 32'd0);
    end

    // single spike, ack tied high
    lv.i_ack = 1'b1;
    set_sv(2, 20'h0ABCD);
    spike = 8'h04;
    tick;
    spike = '0;
    chk("s1_pend", 32'(pending), 32'h04);
    chk("s1_early", 32'(lv.o_valid), 32'd0);
    tick;
    offer("s1", 3'd2, 20'h0ABCD);
    chk("s1_pend0", 32'(pending), 32'h00);
    tick;
    chk("s1_once", 32'(lv.o_valid), 32'd0);

    // arbitration order from ptr=0
    do_reset;
    lv.i_ack = 1'b1;
    set_sv(0, 20'h00100);
    set_sv(3, 20'h00103);
    set_sv(7, 20'h00107);
    spike = 8'h89;
    tick;
    spike = '0;
    chk("rr_pend", 32'(pending), 32'h89);
    tick;
    offer("rr_a0", 3'd0, 20'h00100);
    tick;
    offer("rr_a3", 3'd3, 20'h00103);
    tick;
    offer("rr_a7", 3'd7, 20'h00107);
    chk("rr_a_pend", 32'(pending), 32'h00);
    set_sv(0, 20'h00200);
    set_sv(3, 20'h00203);
    spike = 8'h09;
    tick;
    spike = '0;
    tick;
    offer("rr_b0", 3'd0, 20'h00200);
    tick;
    offer("rr_b3", 3'd3, 20'h00203);
    set_sv(1, 20'h00301);
    set_sv(5, 20'h00305);
    spike = 8'h22;
    tick;
    spike = '0;
    tick;
`ifdef LV_ARB_FIXED_PRIO_EN
    offer("pr_c1", 3'd1, 20'h00301);
    tick;
    offer("pr_c5", 3'd5, 20'h00305);
`else
    offer("rr_c5", 3'd5, 20'h00305);
    tick;
    offer("rr_c1", 3'd1, 20'h00301);
`endif

    // backpressure on neuron 4, overflow on neuron 1 meanwhile
    lv.i_ack = 1'b0;
    set_sv(4, 20'h00011);
    spike = 8'h10;
    tick;
    spike = '0;
    tick;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(lv.o_valid), 32'd1);
      chk("bp_idx", 32'(lv.o_idx), 32'd4);
      chk("bp_lv", 32'(lv.o_lv), 32'h00011);
      chk("bp_ovf", 32'(ovf), (i >= 6) ? 32'd1 : 32'd0);
      if (i == 2) begin
        set_sv(1, 20'h00111);
        spike = 8'h02;
      end else if (i == 5) begin
        set_sv(1, 20'h00222);
        spike = 8'h02;
      end else begin
        spike = '0;
      end
      tick;
    end
    chk("bp_hold", 32'(lv.o_valid), 32'd1);
    chk("bp_pend", 32'(pending), 32'h12);
    lv.i_ack = 1'b1;
    tick;
    chk("bp_drop", 32'(lv.o_valid), 32'd0);
    chk("bp_pend1", 32'(pending), 32'h02);
    tick;
    offer("ovf_n1", 3'd1, 20'h00222);
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // ack racing a new rise on the same neuron
    do_reset;
    chk("race_ovf_rst", 32'(ovf), 32'd0);
    lv.i_ack = 1'b1;
    set_sv(6, 20'h00666);
    spike = 8'h40;
    tick;
    spike = '0;
    tick;
    chk("race_v", 32'(lv.o_valid), 32'd1);
    chk("race_idx", 32'(lv.o_idx), 32'd6);
    chk("race_lv", 32'(lv.o_lv), 32'h00666);
    set_sv(6, 20'h00777);
    spike = 8'h40;
    tick;
    spike = '0;
    chk("race_drop", 32'(lv.o_valid), 32'd0);
    chk("race_pend", 32'(pending), 32'h40);
    chk("race_ovf", 32'(ovf), 32'd0);
    tick;
    offer("race_2nd", 3'd6, 20'h00777);
    chk("race_pend0", 32'(pending), 32'h00);
    chk("race_ovf2", 32'(ovf), 32'd0);

    // reset during an offer with three pending
    lv.i_ack = 1'b0;
    set_sv(1, 20'h00011);
    set_sv(2, 20'h00022);
    set_sv(3, 20'h00033);
    spike = 8'h0E;
    tick;
    spike = '0;
    chk("mr_pend", 32'(pending), 32'h0E);
    tick;
    chk("mr_valid", 32'(lv.o_valid), 32'd1);
    chk("mr_idx", 32'(lv.o_idx), 32'd1);
    rst_n = 1'b0;
    set_sv(5, 20'h00555);
    spike = 8'h20;
    tick;
    chk_reset("mr_rst");
    rst_n = 1'b1;
    lv.i_ack = 1'b1;
    tick;
    chk("mr_hold_pend", 32'(pending), 32'h20);
    chk("mr_hold_v", 32'(lv.o_valid), 32'd0);
    tick;
    offer("mr_n5", 3'd5, 20'h00555);
    chk("mr_pend0", 32'(pending), 32'h00);
    tick;
    chk("mr_once_p", 32'(pending), 32'h00);
    chk("mr_once_v", 32'(lv.o_valid), 32'd0);
    spike = '0;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
